// File: rtl/filter_seq_pkg.sv
// filter_seq_pkg: shared widths, drain length and FSM states for the FIR sequencer
package filter_seq_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam int LEN_W = 16;
  localparam int DRAIN_CYCLES = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/filter_mac2.sv
// filter_mac2: registered 2-tap signed multiply-add, low DATA_W bits of the wide sum
module filter_mac2 import filter_seq_pkg::*; #(
  parameter int ADDR_W = filter_seq_pkg::ADDR_W,
  parameter int DATA_W = filter_seq_pkg::DATA_W,
  parameter int COEF_W = filter_seq_pkg::COEF_W
)(
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [COEF_W-1:0] c0,
  input  logic signed [COEF_W-1:0] c1,
  input  logic [ADDR_W-1:0]        waddr,
  output logic                     y_valid,
  output logic [DATA_W-1:0]        y,
  output logic [ADDR_W-1:0]        y_addr
);
  localparam int S = DATA_W + COEF_W + 1;
  logic signed [S-1:0] sum;
  assign sum = S'(a) * S'(c0) + S'(b) * S'(c1);
  always_ff @(posedge clk) begin
    if (rst_i) begin
      y_valid <= 1'b0;
      y <= '0;
      y_addr <= '0;
    end else begin
      y_valid <= valid;
      y <= sum[DATA_W-1:0];
      y_addr <= waddr;
    end
  end
endmodule

// File: rtl/filter_seq_ctrl.sv
// filter_seq_ctrl: start/done sequencer streaming a 2-tap FIR through a dual-read sample memory
module filter_seq_ctrl import filter_seq_pkg::*; #(
  parameter int ADDR_W = filter_seq_pkg::ADDR_W,
  parameter int DATA_W = filter_seq_pkg::DATA_W,
  parameter int COEF_W = filter_seq_pkg::COEF_W,
  parameter int LEN_W = filter_seq_pkg::LEN_W
)(
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [COEF_W-1:0] coef0_i,
  input  logic [COEF_W-1:0] coef1_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_rd_addr_a_o,
  output logic [ADDR_W-1:0] mem_rd_addr_b_o,
  input  logic [DATA_W-1:0] mem_rd_data_a_i,
  input  logic [DATA_W-1:0] mem_rd_data_b_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o
);
  state_t state, nxt;
  logic [LEN_W-1:0] cnt, len_q;
  logic [COEF_W-1:0] c0, c1;
  logic [ADDR_W-1:0] wa, wa2;
  logic v2;
  always_comb begin
    nxt = state == IDLE ? (start_i ? (len_i == '0 ? DONE : RUN) : IDLE)
        : state == RUN ? (cnt == len_q ? DRAIN : RUN)
        : state == DRAIN ? (cnt == LEN_W'(DRAIN_CYCLES - 1) ? DONE : DRAIN)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      len_q <= '0;
      c0 <= '0;
      c1 <= '0;
      mem_rd_addr_a_o <= '0;
      mem_rd_addr_b_o <= '0;
      wa <= '0;
      wa2 <= '0;
      v2 <= 1'b0;
    end else begin
      state <= nxt;
      v2 <= state == RUN;
      wa2 <= wa;
      if (state == IDLE && start_i) begin
        len_q <= len_i;
        c0 <= coef0_i;
        c1 <= coef1_i;
        mem_rd_addr_a_o <= src_base_i;
        mem_rd_addr_b_o <= src_base_i + ADDR_W'(1);
        wa <= dst_base_i;
        cnt <= LEN_W'(1);
      end else if (state == RUN) begin
        cnt <= nxt == DRAIN ? '0 : cnt + LEN_W'(1);
        mem_rd_addr_a_o <= mem_rd_addr_a_o + ADDR_W'(1);
        mem_rd_addr_b_o <= mem_rd_addr_b_o + ADDR_W'(1);
        wa <= wa + ADDR_W'(1);
      end else if (state == DRAIN) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end
  assign busy_o = state == RUN || state == DRAIN;
  assign done_o = state == DONE;
  filter_mac2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac (
    .clk(clk),
    .rst_i(rst_i),
    .valid(v2),
    .a(mem_rd_data_a_i),
    .b(mem_rd_data_b_i),
    .c0(c0),
    .c1(c1),
    .waddr(wa2),
    .y_valid(mem_we_o),
    .y(mem_wr_data_o),
    .y_addr(mem_wr_addr_o)
  );
endmodule

// File: tb/tb_filter_seq_ctrl.sv
// tb_filter_seq_ctrl: scoreboard bench for the FIR sequencer against a behavioural memory
module tb_filter_seq_ctrl;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [14:0] src_base = '0, dst_base = '0;
  logic [15:0] len = '0, coef0 = '0, coef1 = '0;
  logic busy, done, we;
  logic [14:0] ra, rb, wa;
  logic [31:0] rda = '0, rdb = '0, wd;
  logic [31:0] mem [0:32767];
  int cyc = 0;
  int compares = 0;
  int mismatches = 0;
  typedef struct {logic [14:0] a; logic [31:0] d; int c;} exp_t;
  exp_t q[$];
  filter_seq_ctrl dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i),
    .src_base_i(src_base), .dst_base_i(dst_base), .len_i(len),
    .coef0_i(coef0), .coef1_i(coef1),
    .busy_o(busy), .done_o(done),
    .mem_rd_addr_a_o(ra), .mem_rd_addr_b_o(rb),
    .mem_rd_data_a_i(rda), .mem_rd_data_b_i(rdb),
    .mem_we_o(we), .mem_wr_addr_o(wa), .mem_wr_data_o(wd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    rda <= mem[ra];
    rdb <= mem[rb];
    if (we) mem[wa] = wd;
  end
  always @(negedge clk) begin
    if (we) begin
      compares++;
      if (q.size() == 0) begin
        mismatches++;
        $display("FAIL unexpected_write: addr=%h data=%h cycle=%0d, required no write", wa, wd, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wa !== e.a || wd !== e.d || cyc !== e.c) begin
          mismatches++;
          $display("FAIL write: addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d", wa, wd, cyc, e.a, e.d, e.c);
        end
      end
    end
  end
  function automatic logic [31:0] fir(input logic [31:0] xa, xb, input logic [15:0] k0, k1);
    longint s;
    s = longint'($signed(xa)) * longint'($signed(k0)) + longint'($signed(xb)) * longint'($signed(k1));
    return s[31:0];
  endfunction
  task automatic run_job(input logic [14:0] src, dst, input logic [15:0] n, k0, k1, input bit repulse);
    int c1c;
    exp_t e;
    logic [14:0] ia, ib;
    @(negedge clk);
    src_base = src; dst_base = dst; len = n; coef0 = k0; coef1 = k1; start_i = 1'b1;
    @(posedge clk);
    #1;
    c1c = cyc;
    start_i = 1'b0;
    for (int k = 1; k <= int'(n); k++) begin
      ia = src + 15'(k - 1);
      ib = src + 15'(k);
      e.a = dst + 15'(k - 1);
      e.d = fir(mem[ia], mem[ib], k0, k1);
      e.c = c1c + k + 1;
      q.push_back(e);
    end
    for (int t = 1; t <= int'(n) + 5; t++) begin
      @(negedge clk);
      compares++;
      if (busy !== (n != 0 && t <= int'(n) + 2)) begin
        mismatches++;
        $display("FAIL busy: C%0d got %b required %b", t, busy, (n != 0 && t <= int'(n) + 2));
      end
      compares++;
      if (done !== (n == 0 ? t == 1 : t == int'(n) + 3)) begin
        mismatches++;
        $display("FAIL done: C%0d got %b required %b", t, done, (n == 0 ? t == 1 : t == int'(n) + 3));
      end
      if (t <= int'(n)) begin
        ia = src + 15'(t - 1);
        ib = src + 15'(t);
        compares++;
        if (ra !== ia || rb !== ib) begin
          mismatches++;
          $display("FAIL rd_addr: C%0d got a=%h b=%h required a=%h b=%h", t, ra, rb, ia, ib);
        end
      end
      if (repulse && t == 2) begin
        start_i = 1'b1; len = 16'd20; src_base = 15'h1234; dst_base = 15'h0;
      end
      if (repulse && t == 3) start_i = 1'b0;
    end
    compares++;
    if (q.size() != 0) begin
      mismatches++;
      $display("FAIL missing_writes: %0d outstanding, required 0", q.size());
      q.delete();
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    compares++;
    if ({busy, done, we} !== 3'b000 || ra !== '0 || rb !== '0 || wa !== '0 || wd !== '0) begin
      mismatches++;
      $display("FAIL reset: busy=%b done=%b we=%b ra=%h rb=%h wa=%h wd=%h, required all 0", busy, done, we, ra, rb, wa, wd);
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic();
    run_job(15'd0, 15'd100, 16'd4, 16'd1, 16'd1, 1'b0);
    run_job(15'd10, 15'd200, 16'd1, 16'd2, 16'hFFFF, 1'b0);
  endtask
  task automatic test_zero_len();
    run_job(15'd50, 15'd60, 16'd0, 16'd1, 16'd1, 1'b0);
  endtask
  task automatic test_wrap();
    run_job(15'h7FFF, 15'h7FFF, 16'd2, 16'd1, 16'd0, 1'b0);
  endtask
  task automatic test_random_data();
    for (int i = 500; i < 508; i++) mem[i] = $urandom;
    run_job(15'd500, 15'd600, 16'd6, 16'hFED4, 16'd1234, 1'b0);
  endtask
  task automatic test_repulse();
    run_job(15'd20, 15'd400, 16'd5, 16'd1, 16'd2, 1'b1);
  endtask
  task automatic test_back_to_back();
    run_job(15'd30, 15'd450, 16'd3, 16'd5, 16'hFFFD, 1'b0);
    run_job(15'd40, 15'd460, 16'd2, 16'h7FFF, 16'h8000, 1'b0);
  endtask
  task automatic test_reset_midjob();
    exp_t e;
    int c1c;
    @(negedge clk);
    src_base = 15'd0; dst_base = 15'd300; len = 16'd8; coef0 = 16'd3; coef1 = 16'd1; start_i = 1'b1;
    @(posedge clk);
    #1;
    c1c = cyc;
    start_i = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      e.a = 15'(300 + k - 1);
      e.d = fir(mem[k - 1], mem[k], 16'd3, 16'd1);
      e.c = c1c + k + 1;
      q.push_back(e);
    end
    repeat (4) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    compares++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      mismatches++;
      $display("FAIL abort: busy=%b we=%b in C5, required 0 0", busy, we);
    end
    rst_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      compares++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        mismatches++;
        $display("FAIL post_abort: busy=%b done=%b, required 0 0", busy, done);
      end
    end
    compares++;
    if (q.size() != 0) begin
      mismatches++;
      $display("FAIL abort_writes: %0d outstanding, required 0", q.size());
      q.delete();
    end
    run_job(15'd5, 15'd320, 16'd3, 16'd1, 16'd1, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = i;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_random_data();
    test_repulse();
    test_back_to_back();
    test_reset_midjob();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end
endmodule
